// File: rtl/scroll_pattern_if.sv
// Button, handshake and frame signals between the scroll pattern controller
// and its environment; master drives buttons/config, slave is the controller.
interface scroll_pattern_if #(
  parameter int GROUP_W    = 24,
  parameter int NUM_GROUPS = 5,
  parameter int SPD_W      = 3
);
  localparam int FRAME_W = GROUP_W * NUM_GROUPS;
  localparam int POS_W   = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  logic               go;
  logic               up;
  logic               down;
  logic               left;
  logic               right;
  logic               ready2go;
  logic [SPD_W-1:0]   speed_sel;
  logic               bounce_en;
  logic [GROUP_W-1:0] seed_in;
  logic [FRAME_W-1:0] frame_out;
  logic               send_go;
  logic [POS_W-1:0]   position;
  logic               busy;

  modport master (
    output go, up, down, left, right, ready2go, speed_sel, bounce_en, seed_in,
    input  frame_out, send_go, position, busy
  );

  modport slave (
    input  go, up, down, left, right, ready2go, speed_sel, bounce_en, seed_in,
    output frame_out, send_go, position, busy
  );
endinterface

// File: rtl/scroll_pattern_ctrl.sv
// Button-driven frame rotator: steps a NUM_GROUPS-group frame at a selectable
// rate and hands each new frame to the shift-register sender via send_go.
module scroll_pattern_ctrl #(
  parameter int GROUP_W    = 24,
  parameter int NUM_GROUPS = 5,
  parameter int SPD_W      = 3,
  parameter int BASE_TICKS = 50_000_000,
  parameter int CNT_W      = 26
) (
  input logic               clk,
  input logic               reset,
  scroll_pattern_if.slave   bus
);
  localparam int FRAME_W = GROUP_W * NUM_GROUPS;
  localparam int POS_W   = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN_UP, RUN_DN, RUN_LT, RUN_RT, RELEASE
  } state_t;

  state_t             state;
  state_t             dir_req;
  logic [FRAME_W-1:0] frame;
  logic [POS_W-1:0]   position;
  logic               send_go;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   period;
  logic               bounce;
  logic               pending;
  logic               any_btn;
  logic               tick;
  logic [FRAME_W-1:0] default_frame;

  function automatic logic [FRAME_W-1:0] rot_groups_l(input logic [FRAME_W-1:0] f);
    logic [GROUP_W-1:0] grp;
    rot_groups_l = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      grp = f[g*GROUP_W +: GROUP_W];
      rot_groups_l[g*GROUP_W +: GROUP_W] = {grp[GROUP_W-2:0], grp[GROUP_W-1]};
    end
  endfunction

  function automatic logic [FRAME_W-1:0] rot_groups_r(input logic [FRAME_W-1:0] f);
    logic [GROUP_W-1:0] grp;
    rot_groups_r = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      grp = f[g*GROUP_W +: GROUP_W];
      rot_groups_r[g*GROUP_W +: GROUP_W] = {grp[0], grp[GROUP_W-1:1]};
    end
  endfunction

  function automatic logic [FRAME_W-1:0] frame_rotl(input logic [FRAME_W-1:0] f);
    return {f[FRAME_W-GROUP_W-1:0], f[FRAME_W-1 -: GROUP_W]};
  endfunction

  function automatic logic [FRAME_W-1:0] frame_rotr(input logic [FRAME_W-1:0] f);
    return {f[GROUP_W-1:0], f[FRAME_W-1:GROUP_W]};
  endfunction

  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
    return (p == POS_W'(NUM_GROUPS - 1)) ? '0 : p + POS_W'(1);
  endfunction

  function automatic logic [POS_W-1:0] pos_dec(input logic [POS_W-1:0] p);
    return (p == '0) ? POS_W'(NUM_GROUPS - 1) : p - POS_W'(1);
  endfunction

  assign default_frame = {NUM_GROUPS{bus.seed_in}};
  assign any_btn       = bus.go | bus.up | bus.down | bus.left | bus.right;
  assign tick          = (count == '0);

  // IDLE doubles as "no direction requested"; priority is up > down > left > right.
  always_comb begin
    dir_req = IDLE;
    if (bus.up)         dir_req = RUN_UP;
    else if (bus.down)  dir_req = RUN_DN;
    else if (bus.left)  dir_req = RUN_LT;
    else if (bus.right) dir_req = RUN_RT;
  end

  // NOTE: every register here is assigned non-blocking, so all branches
  // read pre-edge values and later assignments never see earlier ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      frame    <= default_frame;
      position <= '0;
      send_go  <= 1'b0;
      count    <= '0;
      pending  <= 1'b0;
      period   <= CNT_W'(BASE_TICKS);
      bounce   <= 1'b0;
    end else begin
      send_go <= 1'b0;
      case (state)
        IDLE: begin
          period <= CNT_W'(BASE_TICKS >> bus.speed_sel);
          bounce <= bus.bounce_en;
          if (bus.ready2go) begin
            if (bus.go) begin
              state <= LOAD;
            end else if (dir_req != IDLE) begin
              state   <= dir_req;
              count   <= '0;
              pending <= 1'b0;
            end
          end
        end

        LOAD: begin
          frame    <= default_frame;
          position <= '0;
          send_go  <= 1'b1;
          state    <= RELEASE;
        end

        RUN_UP, RUN_DN, RUN_LT, RUN_RT: begin
          if (bus.go) begin
            state <= RELEASE;
          end else if (dir_req != IDLE && dir_req != state) begin
            state   <= dir_req;
            count   <= '0;
            pending <= 1'b0;
          end else begin
            count <= (count == period - CNT_W'(1)) ? '0 : count + CNT_W'(1);
            // A tick that lands while a step is already owed merges into it.
            if (tick || pending) begin
              if (bus.ready2go) begin
                pending <= 1'b0;
                send_go <= 1'b1;
                case (state)
                  RUN_UP: frame <= rot_groups_l(frame);
                  RUN_DN: frame <= rot_groups_r(frame);
                  RUN_LT: begin
                    if (bounce && position == '0) begin
                      frame    <= frame_rotr(frame);
                      position <= pos_inc(position);
                      state    <= RUN_RT;
                    end else begin
                      frame    <= frame_rotl(frame);
                      position <= pos_dec(position);
                    end
                  end
                  default: begin
                    if (bounce && position == POS_W'(NUM_GROUPS - 1)) begin
                      frame    <= frame_rotl(frame);
                      position <= pos_dec(position);
                      state    <= RUN_LT;
                    end else begin
                      frame    <= frame_rotr(frame);
                      position <= pos_inc(position);
                    end
                  end
                endcase
              end else begin
                pending <= 1'b1;
              end
            end
          end
        end

        RELEASE: begin
          if (!any_btn) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.frame_out = frame;
  assign bus.position  = position;
  assign bus.send_go   = send_go;
  assign bus.busy      = (state != IDLE);
endmodule
